data_mem_responder: RTL and testbench

//  Memory-side end of the processor load/store/fetch interface: a single-port, word-addressed
//  RAM that answers one request at a time over a valid/ready request channel and a

---
 rtl/mem_if_pkg.sv | 9 +
 rtl/mem_array_1rw.sv | 18 +
 rtl/data_mem_responder.sv | 76 +++++++
 tb/tb_data_mem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared state type, widths and address range helper for the data memory responder
package mem_if_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W = MEM_DATA_W / 8;
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr >> 2) < depth;
  endfunction
endpackage

// File: rtl/mem_array_1rw.sv
// mem_array_1rw: single-port byte-write-enabled RAM with registered read data
module mem_array_1rw import mem_if_pkg::*; #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           re,
  input  logic [MEM_BE_W-1:0]            we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [MEM_DATA_W-1:0]          wdata,
  output logic [MEM_DATA_W-1:0]          rdata
);
  logic [MEM_DATA_W-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    for (int i = 0; i < MEM_BE_W; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed RAM answering one valid/ready request at a time with programmable wait states
module data_mem_responder import mem_if_pkg::*; #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [MEM_DATA_W-1:0] req_wdata,
  input  logic [MEM_BE_W-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [MEM_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [MEM_DATA_W-1:0] wdata_q, wdata_d;
  logic [MEM_BE_W-1:0] be_q, be_d;
  logic err_q, err_d, rd_q, rd_d;
  logic acc, bad, take, done;
  logic [MEM_DATA_W-1:0] ram_rdata;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_err = err_q;
  assign rsp_rdata = rd_q ? ram_rdata : '0;
  always_comb begin
    take = state_q == IDLE && req_valid;
    acc = state_q == WAIT && cnt_q == 4'd0;
    done = state_q == RESP && rsp_ready;
    bad = |addr_q[1:0] || !addr_in_range(addr_q, DEPTH_WORDS);
    state_d = take ? WAIT : acc ? RESP : done ? IDLE : state_q;
    cnt_d = take ? 4'(LATENCY) : (state_q == WAIT && !acc) ? cnt_q - 4'd1 : cnt_q;
    write_d = take ? req_write : write_q;
    addr_d = take ? req_addr : addr_q;
    wdata_d = take ? req_wdata : wdata_q;
    be_d = take ? req_be : be_q;
    err_d = acc ? bad : done ? 1'b0 : err_q;
    rd_d = acc ? !bad && !write_q : done ? 1'b0 : rd_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      err_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      write_q <= write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      err_q <= err_d;
      rd_q <= rd_d;
    end
  end
  mem_array_1rw #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk  (clk),
    .re   (acc && !bad && !write_q),
    .we   ((acc && !bad && write_q) ? be_q : '0),
    .addr (addr_q[AW+1:2]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table, corner-case and randomized checks of the responder against a word-array model
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic sel = 1'b0, tie = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_be = '0;
  logic rdy_a, rdy_b, vld_a, vld_b, err_a, err_b;
  logic [31:0] rd_a, rd_b;
  logic rdy_m, vld_m, err_m;
  logic [31:0] rd_m;
  assign rdy_m = sel ? rdy_b : rdy_a;
  assign vld_m = sel ? vld_b : vld_a;
  assign err_m = sel ? err_b : err_a;
  assign rd_m = sel ? rd_b : rd_a;
  int vectors = 0, miscompares = 0;
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(rdy_a),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vld_a), .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_err(err_a)
  );
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(rdy_b),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vld_b), .rsp_ready(rsp_ready), .rsp_rdata(rd_b), .rsp_err(err_b)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    while (!rdy_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
  endtask
  task automatic get_rsp(output logic [31:0] rdata, output logic err, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!vld_m && lat < 50);
    if (!vld_m) check("rsp_timeout", 32'(vld_m), 32'd1);
    rdata = rd_m;
    err = err_m;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rsp_drop", 32'({vld_m, err_m}), 32'd0);
    check("rsp_rdata_clear", rd_m, 32'd0);
    if (!tie) rsp_ready = 1'b0;
  endtask
  task automatic txn(input string name, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic er;
    int lat;
    issue(w, a, d, be);
    get_rsp(rd, er, lat);
    check({name, "_rdata"}, rd, exp_rd);
    check({name, "_err"}, 32'(er), 32'(exp_err));
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask
  typedef struct {
    logic w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0] be;
    logic [31:0] rd;
    logic err;
  } vec_t;
  vec_t tab[18];
  logic [31:0] model[16];
  initial begin
    logic [31:0] rd, a, d, mask;
    logic er, w, bad;
    logic [3:0] be;
    int lat;
    tab[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    tab[1]  = '{1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0};
    tab[2]  = '{1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0};
    tab[3]  = '{1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0};
    tab[4]  = '{1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0};
    tab[5]  = '{1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1};
    tab[6]  = '{1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1};
    tab[7]  = '{1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0};
    tab[8]  = '{1'b1, 32'h0, 32'h12345678, 4'hF, 32'h0, 1'b0};
    tab[9]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
    tab[10] = '{1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
    tab[11] = '{1'b0, 32'h0, 32'h0, 4'hF, 32'h12345678, 1'b0};
    tab[12] = '{1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0};
    tab[13] = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
    tab[14] = '{1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0};
    tab[15] = '{1'b0, 32'h80000010, 32'h0, 4'hF, 32'h0, 1'b1};
    tab[16] = '{1'b1, 32'h40, 32'h0, 4'hF, 32'h0, 1'b0};
    tab[17] = '{1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check("reset_a_ready", 32'(rdy_a), 32'd1);
    check("reset_a_rsp", 32'({vld_a, err_a}), 32'd0);
    check("reset_a_rdata", rd_a, 32'd0);
    check("reset_b_ready", 32'(rdy_b), 32'd1);
    check("reset_b_rsp", 32'({vld_b, err_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++)
      txn($sformatf("tab%0d", i), tab[i].w, tab[i].a, tab[i].d, tab[i].be, tab[i].rd, tab[i].err, 3);
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!vld_a && lat < 50);
    check("hold_lat", 32'(lat), 32'd3);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(vld_a), 32'd1);
      check("hold_rdata", rd_a, 32'hDEADBEEF);
      check("hold_err", 32'(err_a), 32'd0);
      check("hold_ready", 32'(rdy_a), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("hold_taken_valid", 32'(vld_a), 32'd0);
    check("hold_taken_rdata", rd_a, 32'd0);
    check("hold_taken_ready", 32'(rdy_a), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 32'h13;
    check("hold_next_accepted", 32'(rdy_a), 32'd0);
    get_rsp(rd, er, lat);
    check("hold_next_rdata", rd, 32'h11BB33DD);
    check("hold_next_lat", 32'(lat), 32'd3);
    issue(1'b1, 32'h40, 32'h5, 4'hF);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(rdy_a), 32'd1);
    check("midrst_rsp", 32'({vld_a, err_a}), 32'd0);
    check("midrst_rdata", rd_a, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_rsp", 32'(vld_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn("midrst_load", 1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 1'b0, 3);
    sel = 1'b1;
    tie = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      txn("init", 1'b1, 32'(i * 4), model[i], 4'hF, 32'h0, 1'b0, 1);
    end
    for (int i = 0; i < 20; i++) begin
      int idx, kind;
      w = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 15);
      kind = $urandom_range(0, 7);
      a = kind == 0 ? 32'(idx * 4 + $urandom_range(1, 3)) : kind == 1 ? 32'(DEPTH * 4 + idx * 4) : 32'(idx * 4);
      d = $urandom;
      be = 4'($urandom);
      bad = (a % 4 != 0) || (a >= DEPTH * 4);
      rd = 32'h0;
      if (!bad && !w) rd = model[a / 4];
      if (!bad && w) begin
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        model[a / 4] = (model[a / 4] & ~mask) | (d & mask);
      end
      txn($sformatf("rnd%0d", i), w, a, d, be, rd, bad, 1);
    end
    for (int i = 0; i < 16; i++)
      txn($sformatf("final%0d", i), 1'b0, 32'(i * 4), 32'h0, 4'hF, model[i], 1'b0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
